// File: rtl/sequent_shift_display.sv
// Digit-sequence display engine.
// A free-running prescaler produces a tick every DIV clocks. On each tick a row of
// NUM_DIGITS hex digits is held, shifted (new digit enters on the right), or rotated
// left or right. A per-digit valid mask follows the same movement so that digits never
// written can be blanked. Each digit is encoded to an active-low 7-segment pattern.
module sequent_shift_display #(
   parameter int NUM_DIGITS    = 6,
   parameter int DIV           = 25000000,
   parameter int BLANK_INVALID = 1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [3:0]                    data_i,
   input  logic [1:0]                    mode_i,
   input  logic                          clr_i,
   output logic [7*NUM_DIGITS-1:0]       seg_o,
   output logic [4*NUM_DIGITS-1:0]       digits_o,
   output logic [$clog2(NUM_DIGITS+1)-1:0] cnt_o,
   output logic                          full_o,
   output logic                          tick_o
);

   localparam int CNT_W = $clog2(NUM_DIGITS+1);
   localparam int DIV_W = $clog2(DIV);

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_SHIFT = 2'b01,
      MODE_ROTL  = 2'b10,
      MODE_ROTR  = 2'b11
   } mode_e;

   mode_e modeSel;

   logic [DIV_W-1:0]        preQ, preD;
   logic [4*NUM_DIGITS-1:0] digQ, digD;
   logic [NUM_DIGITS-1:0]   validQ, validD;
   logic [CNT_W-1:0]        cntQ, cntD;

   assign modeSel  = mode_e'(mode_i);
   assign tick_o   = (preQ == DIV_W'(DIV-1));
   assign digits_o = digQ;
   assign cnt_o    = cntQ;
   assign full_o   = (cntQ == CNT_W'(NUM_DIGITS));

   // Active-low hex to 7-segment lookup, bit0 = segment a.
   function automatic logic [6:0] hexToSeg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Prescaler wraps at DIV-1; a clear restarts it so the next tick is a full period away.
   always_comb begin
      preD = preQ + DIV_W'(1);
      if (clr_i || tick_o) begin
         preD = '0;
      end
   end

   // Digit, valid-mask and fill-count update; clear beats a coincident tick.
   always_comb begin
      digD   = digQ;
      validD = validQ;
      cntD   = cntQ;
      if (clr_i) begin
         digD   = '0;
         validD = '0;
         cntD   = '0;
      end else if (tick_o) begin
         case (modeSel)
            MODE_SHIFT: begin
               digD   = {digQ[4*NUM_DIGITS-5:0], data_i};
               validD = {validQ[NUM_DIGITS-2:0], 1'b1};
               if (cntQ != CNT_W'(NUM_DIGITS)) begin
                  cntD = cntQ + CNT_W'(1);
               end
            end
            MODE_ROTL: begin
               digD   = {digQ[4*NUM_DIGITS-5:0], digQ[4*NUM_DIGITS-1:4*NUM_DIGITS-4]};
               validD = {validQ[NUM_DIGITS-2:0], validQ[NUM_DIGITS-1]};
            end
            MODE_ROTR: begin
               digD   = {digQ[3:0], digQ[4*NUM_DIGITS-1:4]};
               validD = {validQ[0], validQ[NUM_DIGITS-1:1]};
            end
            default: begin
               digD = digQ;
            end
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         preQ   <= '0;
         digQ   <= '0;
         validQ <= '0;
         cntQ   <= '0;
      end else begin
         preQ   <= preD;
         digQ   <= digD;
         validQ <= validD;
         cntQ   <= cntD;
      end
   end

   // Per-digit segment encode; unwritten digits go dark when blanking is enabled.
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_seg
      always_comb begin
         seg_o[7*i +: 7] = hexToSeg(digQ[4*i +: 4]);
         if ((BLANK_INVALID != 0) && !validQ[i]) begin
            seg_o[7*i +: 7] = 7'h7F;
         end
      end
   end

endmodule

// File: tb/tb_sequent_shift_display.sv
// Bench for sequent_shift_display with NUM_DIGITS=6, DIV=4.
// Stimulus queues a hand-computed expected state for every tick it drives; a monitor
// pops one entry after each tick edge and compares it with the DUT.
module tb_sequent_shift_display;

   localparam logic [1:0] HOLD  = 2'b00;
   localparam logic [1:0] SHIFT = 2'b01;
   localparam logic [1:0] ROTL  = 2'b10;
   localparam logic [1:0] ROTR  = 2'b11;

   logic        clk;
   logic        rst_n;
   logic [3:0]  data;
   logic [1:0]  mode;
   logic        clr;
   logic [41:0] seg0, seg1;
   logic [23:0] dig0, dig1;
   logic [2:0]  cnt0, cnt1;
   logic        full0, full1, tick0, tick1;

   typedef struct {
      string       name;
      logic [23:0] dig;
      logic [2:0]  cnt;
      logic [5:0]  mask;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   logic pend  = 1'b0;

   sequent_shift_display #(.NUM_DIGITS(6), .DIV(4), .BLANK_INVALID(1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .data_i(data), .mode_i(mode), .clr_i(clr),
      .seg_o(seg0), .digits_o(dig0), .cnt_o(cnt0), .full_o(full0), .tick_o(tick0)
   );

   sequent_shift_display #(.NUM_DIGITS(6), .DIV(4), .BLANK_INVALID(0)) dutNoBlank (
      .clk_i(clk), .rst_ni(rst_n), .data_i(data), .mode_i(mode), .clr_i(clr),
      .seg_o(seg1), .digits_o(dig1), .cnt_o(cnt1), .full_o(full1), .tick_o(tick1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] hexSeg(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   function automatic logic [41:0] segOf(input logic [23:0] d, input logic [5:0] m);
      logic [41:0] s;
      for (int i = 0; i < 6; i++) begin
         s[7*i +: 7] = m[i] ? hexSeg(d[4*i +: 4]) : 7'h7F;
      end
      return s;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: remember whether the DUT is about to act on this edge, then check half a cycle later.
   always @(posedge clk) begin
      pend <= tick0 && rst_n && !clr;
   end

   always @(negedge clk) begin
      if (pend) begin
         if (sb.size() == 0) begin
            checkOutput("sb_underflow", 64'd0, 64'd1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput({e.name, "_dig"},  64'(dig0),  64'(e.dig));
            checkOutput({e.name, "_cnt"},  64'(cnt0),  64'(e.cnt));
            checkOutput({e.name, "_full"}, 64'(full0), 64'(e.cnt == 3'd6));
            checkOutput({e.name, "_seg"},  64'(seg0),  64'(segOf(e.dig, e.mask)));
         end
      end
   end

   task automatic waitTick();
      for (int i = 0; i < 10 && !tick0; i++) @(negedge clk);
      checkOutput("tick_arrives", 64'(tick0), 64'd1);
   endtask

   task automatic applyStimulus(input string name, input logic [1:0] m, input logic [3:0] d,
                                input logic [23:0] expDig, input logic [2:0] expCnt,
                                input logic [5:0] expMask);
      exp_t e;
      waitTick();
      mode = m;
      data = d;
      e.name = name; e.dig = expDig; e.cnt = expCnt; e.mask = expMask;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic checkResetState(input string name);
      checkOutput({name, "_dig"},   64'(dig0),  64'd0);
      checkOutput({name, "_cnt"},   64'(cnt0),  64'd0);
      checkOutput({name, "_full"},  64'(full0), 64'd0);
      checkOutput({name, "_tick"},  64'(tick0), 64'd0);
      checkOutput({name, "_seg"},   64'(seg0),  64'({6{7'h7F}}));
      checkOutput({name, "_seg_noblank"}, 64'(seg1), 64'({6{7'h40}}));
   endtask

   // Hold mode from a cleared state: tick on every 4th clock, and queue an all-zero result for each.
   task automatic runIdle(input string name, input int cycles);
      exp_t e;
      mode = HOLD;
      for (int k = 1; k <= cycles; k++) begin
         checkOutput($sformatf("%s_tick_c%0d", name, k), 64'(tick0), 64'(k % 4 == 0));
         if (k % 4 == 0) begin
            e.name = name; e.dig = 24'h0; e.cnt = 3'd0; e.mask = 6'h0;
            sb.push_back(e);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int blanks;
      rst_n = 1'b1; mode = HOLD; data = 4'h0; clr = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk); @(negedge clk);
      checkResetState("reset");
      rst_n = 1'b1;

      // Hold from reset: ticks on clocks 4, 8, 12 and nothing changes.
      runIdle("hold", 12);
      checkOutput("hold_seg_noblank", 64'(seg1), 64'({6{7'h40}}));

      // Three shifts.
      applyStimulus("shift1", SHIFT, 4'h1, 24'h000001, 3'd1, 6'b000001);
      applyStimulus("shift2", SHIFT, 4'h2, 24'h000012, 3'd2, 6'b000011);
      applyStimulus("shift3", SHIFT, 4'h3, 24'h000123, 3'd3, 6'b000111);
      checkOutput("shift3_seg_low",  64'(seg0[20:0]),  64'({7'h79, 7'h24, 7'h30}));
      checkOutput("shift3_seg_high", 64'(seg0[41:21]), 64'({3{7'h7F}}));

      // Fill past capacity with 1..8.
      applyStimulus("fill1", SHIFT, 4'h1, 24'h001231, 3'd4, 6'b001111);
      applyStimulus("fill2", SHIFT, 4'h2, 24'h012312, 3'd5, 6'b011111);
      applyStimulus("fill3", SHIFT, 4'h3, 24'h123123, 3'd6, 6'b111111);
      applyStimulus("fill4", SHIFT, 4'h4, 24'h231234, 3'd6, 6'b111111);
      applyStimulus("fill5", SHIFT, 4'h5, 24'h312345, 3'd6, 6'b111111);
      applyStimulus("fill6", SHIFT, 4'h6, 24'h123456, 3'd6, 6'b111111);
      applyStimulus("fill7", SHIFT, 4'h7, 24'h234567, 3'd6, 6'b111111);
      applyStimulus("fill8", SHIFT, 4'h8, 24'h345678, 3'd6, 6'b111111);
      blanks = 0;
      for (int i = 0; i < 6; i++) if (seg0[7*i +: 7] == 7'h7F) blanks++;
      checkOutput("fill_no_blank", 64'(blanks), 64'd0);

      // Rotations on a full row, then a hold tick with junk data.
      applyStimulus("rotl",  ROTL, 4'hF, 24'h456783, 3'd6, 6'b111111);
      applyStimulus("rotr1", ROTR, 4'hF, 24'h345678, 3'd6, 6'b111111);
      applyStimulus("rotr2", ROTR, 4'hF, 24'h834567, 3'd6, 6'b111111);
      applyStimulus("holdF", HOLD, 4'hF, 24'h834567, 3'd6, 6'b111111);

      // Clear on a shift tick: tick still pulses, action lost, then held quiet.
      waitTick();
      mode = SHIFT; data = 4'h7; clr = 1'b1;
      @(negedge clk);
      checkOutput("clr_dig",  64'(dig0),  64'd0);
      checkOutput("clr_cnt",  64'(cnt0),  64'd0);
      checkOutput("clr_full", 64'(full0), 64'd0);
      checkOutput("clr_seg",  64'(seg0),  64'({6{7'h7F}}));
      for (int k = 0; k < 6; k++) begin
         checkOutput($sformatf("clr_held_tick%0d", k), 64'(tick0), 64'd0);
         @(negedge clk);
      end
      clr = 1'b0;
      runIdle("postclr", 4);

      // Partial fill: blank positions travel with their digits.
      applyStimulus("pshift1", SHIFT, 4'h1, 24'h000001, 3'd1, 6'b000001);
      applyStimulus("pshift2", SHIFT, 4'h2, 24'h000012, 3'd2, 6'b000011);
      applyStimulus("pshift3", SHIFT, 4'h3, 24'h000123, 3'd3, 6'b000111);
      applyStimulus("protl",   ROTL,  4'h0, 24'h001230, 3'd3, 6'b001110);
      checkOutput("protl_seg0_blank", 64'(seg0[6:0]), 64'(7'h7F));
      applyStimulus("protr1",  ROTR,  4'h0, 24'h000123, 3'd3, 6'b000111);
      applyStimulus("protr2",  ROTR,  4'h0, 24'h300012, 3'd3, 6'b100011);
      checkOutput("protr2_seg5", 64'(seg0[41:35]), 64'(7'h30));
      applyStimulus("pshift4", SHIFT, 4'h4, 24'h000124, 3'd4, 6'b000111);

      // Asynchronous reset with cnt=4 and prescaler=2.
      mode = HOLD;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkResetState("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      runIdle("afterreset", 4);

      @(negedge clk);
      checkOutput("sb_drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
